// File: rtl/if_id_hazard_reg_pkg.sv
// Shared pipeline definitions for the IF/ID stage and its hazard check.
// Holds the IF/ID FSM state encodings, the NOP instruction word, and the
// opcode/func constants used by the ID-stage hazard check. It also holds the
// next-state function of the IF/ID FSM.
package if_id_hazard_reg_pkg;

    // IF/ID FSM states: RUN = normal load, HOLD = stalled, SQUASH = flushed.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SQUASH = 2'd2
    } pipe_state_e;

    // sll $0,$0,0 -- the canonical MIPS no-op.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Opcode field values seen by the hazard check.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type func field values.
    localparam logic [5:0] FUNC_SLL = 6'h00;
    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;

    // The next state depends only on this cycle's requests, and stall wins over flush.
    function automatic pipe_state_e next_state(input logic stall, input logic flush);
        pipe_state_e ns;
        if (stall) begin
            ns = ST_HOLD;
        end else if (flush) begin
            ns = ST_SQUASH;
        end else begin
            ns = ST_RUN;
        end
        return ns;
    endfunction

endpackage

// File: rtl/if_id_hazard_reg_sat_counter.sv
// sat_counter: event counter that saturates at all-ones and never wraps.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears the count
//   inc   - count one event on this edge
//   count - current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Counter register: it advances on inc and stops at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/if_id_hazard_reg.sv
// if_id_hazard_reg: IF/ID pipeline register with load-use stall and
// branch/jump flush handling. On each edge, stall has priority over flush,
// and flush has priority over a normal load.
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   stall, flush        - hazard requests from the ID stage
//   IF_inst, IF_pc4     - fetched instruction and its PC+4
//   ID_inst, ID_pc4     - registered instruction and PC+4 sent to decode
//   pc_en, bubble       - combinational PC enable (~stall) and ID/EXE bubble (stall)
//   state               - FSM state (0 RUN, 1 HOLD, 2 SQUASH)
//   stall_cnt/flush_cnt - saturating event counters
//   stall_err           - sticky flag for a stall that lasts two or more cycles
module if_id_hazard_reg
    import if_id_hazard_reg_pkg::*;
#(
    parameter logic [31:0] NOP   = NOP_INST,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      IF_inst,
    input  logic [31:0]      IF_pc4,
    output logic [31:0]      ID_inst,
    output logic [31:0]      ID_pc4,
    output logic             pc_en,
    output logic             bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_err
);

    logic [31:0] id_inst_r;
    logic [31:0] id_pc4_r;
    pipe_state_e state_r;
    logic        stall_err_r;
    logic        flush_inc_s;

    // A flush that arrives during a stall is dropped. The branch re-resolves on the next cycle.
    assign flush_inc_s = ~stall & flush;

    // Pipeline register, FSM state and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_inst_r   <= NOP;
            id_pc4_r    <= 32'h0000_0000;
            state_r     <= ST_RUN;
            stall_err_r <= 1'b0;
        end else begin
            if (stall) begin
                id_inst_r <= id_inst_r;
                id_pc4_r  <= id_pc4_r;
            end else if (flush) begin
                id_inst_r <= NOP;
                id_pc4_r  <= 32'h0000_0000;
            end else begin
                id_inst_r <= IF_inst;
                id_pc4_r  <= IF_pc4;
            end

            state_r <= next_state(stall, flush);

            // A stall that is seen while the FSM is already in HOLD is the second consecutive stall.
            if ((state_r == ST_HOLD) && stall) begin
                stall_err_r <= 1'b1;
            end else begin
                stall_err_r <= stall_err_r;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );

    assign ID_inst   = id_inst_r;
    assign ID_pc4    = id_pc4_r;
    assign state     = state_r;
    assign stall_err = stall_err_r;
    assign pc_en     = ~stall;
    assign bubble    = stall;

endmodule

// File: doc/if_id_hazard_reg.md
IF_ID_HAZARD_REG -- requirements
Module: if_id_hazard_reg

Interface
REQ-001 Parameter: NOP, default 32'h0000_0000, instruction word injected on flush and reset (sll $0,$0,0).
REQ-002 Parameter: CNT_W, default 16, width of the stall and flush event counters.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 stall  in  1  load-use stall request from the ID hazard check; combinational from ID_inst.
REQ-007 flush  in  1  taken branch or jump resolved in ID; squash the instruction fetched this cycle.
REQ-008 IF_inst  in  32  fetched instruction.
REQ-009 IF_pc4  in  32  PC+4 of the fetched instruction.
REQ-010 ID_inst  out  32  registered instruction presented to decode and the hazard check.
REQ-011 ID_pc4  out  32  registered PC+4.
REQ-012 pc_en  out  1  PC write enable; equals ~stall (combinational).
REQ-013 bubble  out  1  zero ID/EXE control fields (wr_en=0, sel_data=0); equals stall (combinational).
REQ-014 state  out  2  FSM state: 0 RUN, 1 HOLD, 2 SQUASH.
REQ-015 stall_cnt  out  CNT_W  count of stall cycles, saturating.
REQ-016 flush_cnt  out  CNT_W  count of accepted flushes, saturating.
REQ-017 stall_err  out  1  sticky flag: stall held for 2 or more consecutive cycles.

Function
REQ-018 Register update priority per rising edge: stall > flush > load.
- stall=1: ID_inst and ID_pc4 hold.
- else flush=1: ID_inst<=NOP, ID_pc4<=0.
- else: ID_inst<=IF_inst, ID_pc4<=IF_pc4.
REQ-019 Flush during stall is ignored, not queued; the branch in ID re-resolves on the next cycle.
REQ-020 FSM next state depends only on this cycle's inputs:
- stall=1 -> HOLD.
- else flush=1 -> SQUASH.
- else -> RUN.
REQ-021 Any state with stall=1 goes to HOLD, so HOLD->HOLD occurs on a consecutive stall.
REQ-022 stall_err sets on the edge where state==HOLD and stall=1; it clears only on reset.
REQ-023 stall_cnt increments on each edge with stall=1; flush_cnt increments on each edge with stall=0 and flush=1; both hold at all-ones (no wrap).
REQ-024 Latency: IF_inst appears on ID_inst one edge after acceptance; a stall adds exactly one edge per stalled cycle.
REQ-025 pc_en and bubble have zero latency and are valid in the same cycle that stall is sampled.

Reset
REQ-026 While rst=1, independent of clk:
- ID_inst=NOP, ID_pc4=0.
- state=RUN.
- stall_cnt=0, flush_cnt=0, stall_err=0.
REQ-027 Reset asserted mid-stall or mid-flush discards the held or pending instruction; the first edge after rst deasserts loads IF_inst normally.
REQ-028 Combinational outputs during reset follow the stall input; with ID_inst=NOP, the hazard check drives stall=0, so pc_en=1 and bubble=0.

Structure
REQ-029 The shared pipeline package holds:
- state encodings RUN, HOLD, SQUASH;
- NOP constant;
- opcode/func constants already used by the hazard check.
REQ-030 One sub-module, sat_counter (parameter CNT_W; ports clk, rst, inc, count), is instantiated twice for stall_cnt and flush_cnt.

Verification
REQ-031 Reset: rst=1 with IF_inst=32'h2008_0005 -> ID_inst=0, state=0, counters=0; after release, next edge ID_inst=32'h2008_0005.
REQ-032 Load-use: hold stall=1 for one cycle while ID_inst=32'h0109_5020 -> ID_inst unchanged, pc_en=0, bubble=1, state=HOLD, stall_cnt=1; next edge loads the new IF_inst, state=RUN.
REQ-033 Flush: flush=1, IF_inst=32'h8c08_0004 -> next ID_inst=0, ID_pc4=0, state=SQUASH, flush_cnt=1.
REQ-034 Simultaneous: stall=1 and flush=1 -> ID_inst held, flush_cnt unchanged, state=HOLD.
REQ-035 Double stall: stall=1 for two consecutive edges -> stall_err=1 after the second edge, stall_cnt=2; stall_err remains set until rst.
REQ-036 Saturation: with CNT_W=2, apply 5 stall cycles -> stall_cnt=3 and no wrap.
